// File: rtl/complex_sum_tree.sv
// complex_sum_tree: pipelined I/Q adder tree over N_CH channels.
// Full-precision tree, then saturate or wrap to W bits at the output.
module complex_sum_tree #(
  parameter int N_CH = 4,
  parameter int W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_CH*W-1:0] in_i,
  input  logic [N_CH*W-1:0] in_q,
  input  logic              sat_en,
  output logic              out_valid,
  output logic [W-1:0]      out_i,
  output logic [W-1:0]      out_q,
  output logic              ovf
);

  localparam int L  = $clog2(N_CH) + 1;
  localparam int S  = L - 1;
  localparam int WS = W + S;

  // Tree nodes, stage by stage: stage s starts at N_CH - (N_CH >> (s-1)).
  logic signed [WS-1:0] sum_i_d [N_CH-1];
  logic signed [WS-1:0] sum_i_q [N_CH-1];
  logic signed [WS-1:0] sum_q_d [N_CH-1];
  logic signed [WS-1:0] sum_q_q [N_CH-1];

  logic [S-1:0] v_d, v_q;
  logic [S-1:0] sat_d, sat_q;

  logic signed [WS-1:0] fin_i, fin_q;
  logic [S:0]           top_i, top_q;
  logic                 ofl_i, ofl_q;

  logic         out_valid_d, out_valid_q;
  logic [W-1:0] out_i_d, out_i_q;
  logic [W-1:0] out_q_d, out_q_q;
  logic         ovf_d, ovf_q;

  function automatic logic [W-1:0] clip(
    input logic signed [WS-1:0] x,
    input logic                 o,
    input logic                 sat
  );
    logic [W-1:0] r;
    r = x[W-1:0];
    if (o && sat)
      r = x[WS-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return r;
  endfunction

  // Adder tree: stage 1 sums input pairs, later stages sum prior-stage pairs.
  always_comb begin
    for (int n = 0; n < N_CH - 1; n++) begin
      sum_i_d[n] = sum_i_q[n];
      sum_q_d[n] = sum_q_q[n];
    end
    for (int k = 0; k < N_CH / 2; k++) begin
      sum_i_d[k] = WS'($signed(in_i[2*k*W +: W]))
                 + WS'($signed(in_i[(2*k+1)*W +: W]));
      sum_q_d[k] = WS'($signed(in_q[2*k*W +: W]))
                 + WS'($signed(in_q[(2*k+1)*W +: W]));
    end
    for (int s = 2; s <= S; s++) begin
      for (int k = 0; k < (N_CH >> s); k++) begin
        sum_i_d[N_CH - (N_CH >> (s-1)) + k] =
          sum_i_q[N_CH - (N_CH >> (s-2)) + 2*k]
          + sum_i_q[N_CH - (N_CH >> (s-2)) + 2*k + 1];
        sum_q_d[N_CH - (N_CH >> (s-1)) + k] =
          sum_q_q[N_CH - (N_CH >> (s-2)) + 2*k]
          + sum_q_q[N_CH - (N_CH >> (s-2)) + 2*k + 1];
      end
    end
  end

  // Valid and sat mode ride alongside their sample.
  always_comb begin
    v_d   = '0;
    sat_d = '0;
    v_d[0]   = in_valid;
    sat_d[0] = sat_en;
    for (int s = 1; s < S; s++) begin
      v_d[s]   = v_q[s-1];
      sat_d[s] = sat_q[s-1];
    end
  end

  // Output stage: overflow detect, then clamp or wrap; hold when idle.
  always_comb begin
    fin_i = sum_i_q[N_CH-2];
    fin_q = sum_q_q[N_CH-2];
    top_i = fin_i[WS-1:W-1];
    top_q = fin_q[WS-1:W-1];
    ofl_i = !((&top_i) || !(|top_i));
    ofl_q = !((&top_q) || !(|top_q));
    out_valid_d = v_q[S-1];
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    ovf_d       = ovf_q;
    if (v_q[S-1]) begin
      out_i_d = clip(fin_i, ofl_i, sat_q[S-1]);
      out_q_d = clip(fin_q, ofl_q, sat_q[S-1]);
      ovf_d   = ofl_i | ofl_q;
    end
  end

  // Valid pipeline, cleared by reset so in-flight samples are dropped.
  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  // Data pipeline needs no reset; valid gating keeps garbage out.
  always_ff @(posedge clk) begin
    sum_i_q <= sum_i_d;
    sum_q_q <= sum_q_d;
    sat_q   <= sat_d;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_complex_sum_tree.sv
// tb_complex_sum_tree: scoreboard bench over four tree configurations.
// Expected outputs come from plain full-precision arithmetic.
module tb_complex_sum_tree;

  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    longint ei;
    longint eq;
    bit     eov;
    int     ecyc;
  } exp_t;

  function automatic void model(
    input  longint s,
    input  int     w,
    input  bit     sat,
    output longint o,
    output bit     ov
  );
    longint mx, mn, m;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    m  = longint'(1) <<< w;
    ov = (s > mx) || (s < mn);
    if (ov && sat) begin
      o = (s > mx) ? mx : mn;
    end else begin
      o = s & (m - 1);
      if (o > mx) o = o - m;
    end
  endfunction

  function automatic longint rnd_val(input int w);
    longint mx, r;
    mx = (longint'(1) <<< (w - 1)) - 1;
    case ($urandom_range(0, 3))
      0: r = mx;
      1: r = -mx - 1;
      default: begin
        r = longint'($urandom) & ((longint'(1) <<< w) - 1);
        if (r > mx) r = r - (longint'(1) <<< w);
      end
    endcase
    return r;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int NC = (c == 0) ? 4 : (c == 1) ? 2 : (c == 2) ? 8 : 16;
    localparam int WW = (c == 0) ? 18 : 12;
    localparam int L  = $clog2(NC) + 1;
    localparam longint MX = (longint'(1) <<< (WW - 1)) - 1;
    localparam longint MN = -MX - 1;
    localparam longint A  = (WW >= 18) ? 1000 : 100;

    logic             rst;
    logic             in_valid;
    logic             sat_en;
    logic [NC*WW-1:0] in_i;
    logic [NC*WW-1:0] in_q;
    logic             out_valid;
    logic [WW-1:0]    out_i;
    logic [WW-1:0]    out_q;
    logic             ovf;

    complex_sum_tree #(.N_CH(NC), .W(WW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_i      (in_i),
      .in_q      (in_q),
      .sat_en    (sat_en),
      .out_valid (out_valid),
      .out_i     (out_i),
      .out_q     (out_q),
      .ovf       (ovf)
    );

    exp_t   q[$];
    exp_t   me;
    longint vi[16];
    longint vq[16];
    int     cyc = 0;
    int     npush = 0;
    int     nout = 0;
    int     n0 = 0;
    bit     mon_en = 1'b0;
    bit     fin = 1'b0;
    longint hold_i = 0;
    longint hold_q = 0;
    bit     hold_o = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input bit sat, input bit push);
      exp_t   e;
      longint si, sq, oi, oq;
      bit     vi_o, vq_o;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b1;
      sat_en   = sat;
      si = 0;
      sq = 0;
      for (int k = 0; k < NC; k++) begin
        in_i[k*WW +: WW] = vi[k][WW-1:0];
        in_q[k*WW +: WW] = vq[k][WW-1:0];
        si += vi[k];
        sq += vq[k];
      end
      if (push) begin
        model(si, WW, sat, oi, vi_o);
        model(sq, WW, sat, oq, vq_o);
        e.ei   = oi;
        e.eq   = oq;
        e.eov  = vi_o | vq_o;
        e.ecyc = cyc + L;
        q.push_back(e);
        npush++;
      end
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sat_en   = 1'($urandom);
        for (int k = 0; k < NC; k++) begin
          in_i[k*WW +: WW] = WW'($urandom);
          in_q[k*WW +: WW] = WW'($urandom);
        end
      end
    endtask

    task automatic fill_rand();
      for (int k = 0; k < NC; k++) begin
        vi[k] = rnd_val(WW);
        vq[k] = rnd_val(WW);
      end
    endtask

    initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      sat_en   = 1'b0;
      in_i     = '0;
      in_q     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      for (int k = 0; k < NC; k++) begin vi[k] = A; vq[k] = -A; end
      send(1'b0, 1'b1);
      idle(4);

      for (int k = 0; k < NC; k++) begin vi[k] = MX; vq[k] = 0; end
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      idle(2);

      for (int k = 0; k < NC; k++) begin vi[k] = MN; vq[k] = 0; end
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      for (int k = 0; k < NC; k++) begin
        vi[k] = (k % 2 == 1) ? MN : MX;
        vq[k] = (k % 2 == 1) ? MX : MN;
      end
      send(1'b1, 1'b1);
      for (int k = 0; k < NC; k++) begin vi[k] = 0; vq[k] = MN; end
      send(1'b1, 1'b1);
      idle(L + 2);

      fill_rand();
      send(1'b0, 1'b0);
      if (L > 2) begin
        fill_rand();
        send(1'b1, 1'b0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      for (int k = 0; k < NC; k++) begin vi[k] = A; vq[k] = 2 * A; end
      send(1'b0, 1'b1);
      idle(L + 2);

      n0 = nout;
      for (int i = 0; i < 20; i++) begin
        idle($urandom_range(0, 2));
        fill_rand();
        send(1'($urandom), 1'b1);
      end
      idle(L + 2);

      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: %0d outputs pending, want 0", c, q.size());
      end
      checks++;
      if (nout - n0 != 20) begin
        errors++;
        $display("FAIL cfg%0d count: got %0d outputs, want 20", c, nout - n0);
      end
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (mon_en) begin
        checks++;
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL cfg%0d spurious: out_valid=1 i=%0d, want none",
                     c, $signed(out_i));
          end else begin
            me = q.pop_front();
            nout++;
            if (longint'($signed(out_i)) !== me.ei ||
                longint'($signed(out_q)) !== me.eq ||
                ovf !== me.eov || cyc != me.ecyc) begin
              errors++;
              $display("FAIL cfg%0d out: got i=%0d q=%0d ovf=%0b cyc=%0d, want i=%0d q=%0d ovf=%0b cyc=%0d",
                       c, $signed(out_i), $signed(out_q), ovf, cyc,
                       me.ei, me.eq, me.eov, me.ecyc);
            end
            hold_i = me.ei;
            hold_q = me.eq;
            hold_o = me.eov;
          end
        end else begin
          if (out_valid !== 1'b0 ||
              longint'($signed(out_i)) !== hold_i ||
              longint'($signed(out_q)) !== hold_q ||
              ovf !== hold_o) begin
            errors++;
            $display("FAIL cfg%0d hold: got v=%0b i=%0d q=%0d ovf=%0b, want v=0 i=%0d q=%0d ovf=%0b",
                     c, out_valid, $signed(out_i), $signed(out_q), ovf,
                     hold_i, hold_q, hold_o);
          end
        end
        if (rst) begin
          hold_i = 0;
          hold_q = 0;
          hold_o = 1'b0;
        end
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_cfg[0].fin && g_cfg[1].fin &&
                 g_cfg[2].fin && g_cfg[3].fin;
    end
    checks++;
    if (!all_done) begin
      errors++;
      $display("FAIL timeout: stimulus done=%0b, want 1", all_done);
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
